// File: rtl/match_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : match_pkg
//  Description : Shared definitions for the match controller and the blocks
//                that consume its outputs (display, player logic).
//                - match_state_t : game_state encoding
//                - WIN_*         : round_winner codes
//                - is_active()   : states in which the second timer runs
//  Revision    : 1.0 - initial release
// ============================================================================
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_FIGHT     = 3'd2,
        ST_P1_WIN    = 3'd3,
        ST_P2_WIN    = 3'd4,
        ST_EQ        = 3'd5,
        ST_ROUND_END = 3'd6
    } match_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Timed states: the second prescaler and down-counter only run here.
    function automatic logic is_active(input match_state_t s);
        return (s == ST_COUNTDOWN) || (s == ST_FIGHT) || (s == ST_ROUND_END);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sec_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sec_down_timer
//  Description : Seconds down-counter with a clock-cycle prescaler.
//                The prescaler counts 0..CLK_HZ-1 while enabled; on CLK_HZ-1
//                it wraps and the counter decrements (saturating at 0).
//                load has priority over everything: it restarts the
//                prescaler and loads the counter, so a load on a tick cycle
//                suppresses that tick's decrement.
//  Ports       : clk, reset (async, active-high)
//                load, load_value[TIMER_W] - restart with a new value
//                enable                    - prescaler/counter run
//                count[TIMER_W]            - current seconds value
//                tick                      - this cycle ends a second
//                zero                      - count is 0
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_down_timer #(
    parameter int CLK_HZ  = 60,
    parameter int TIMER_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               enable,
    output logic [TIMER_W-1:0] count,
    output logic               tick,
    output logic               zero
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] c_presc_max = PW'(CLK_HZ - 1);

    logic [PW-1:0]      r_presc;
    logic [TIMER_W-1:0] r_count;

    assign tick  = enable && (r_presc == c_presc_max);
    assign zero  = (r_count == '0);
    assign count = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (load) begin
            r_presc <= '0;
            r_count <= load_value;
        end else if (enable) begin
            if (tick) begin
                r_presc <= '0;
                if (!zero) begin
                    r_count <= r_count - TIMER_W'(1);
                end
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
//  Module      : match_controller
//  Description : Fighting-game match sequencer: pre-round countdown, timed
//                fight rounds with KO / time-out judgement, post-round hold,
//                and best-of match resolution with a round cap.
//  Ports       : clk, reset (async, active-high)
//                start        - one-cycle start / acknowledge pulse
//                pause        - freeze request (see MATCH_PAUSE_EN)
//                p1_health, p2_health [HEALTH_W] - 0 means KO
//                game_state[3], timer[TIMER_W] (displayed seconds)
//                p1_rounds, p2_rounds, round_num
//                round_start  - one-cycle player-reset pulse on FIGHT entry
//                round_winner - 00 none, 01 P1, 10 P2, 11 draw
//  Config      : `define MATCH_PAUSE_EN to let pause freeze the timer in
//                COUNTDOWN/FIGHT/ROUND_END (KO checks stay live). Without
//                it the pause port is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_controller
    import match_pkg::*;
#(
    parameter int CLK_HZ        = 60,
    parameter int COUNTDOWN_S   = 3,
    parameter int ROUND_S       = 99,
    parameter int ROUND_END_S   = 2,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int HEALTH_W      = 3,
    parameter int TIMER_W       = 7
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               pause,
    input  logic [HEALTH_W-1:0]                p1_health,
    input  logic [HEALTH_W-1:0]                p2_health,
    output logic [2:0]                         game_state,
    output logic [TIMER_W-1:0]                 timer,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0] p1_rounds,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0] p2_rounds,
    output logic [$clog2(MAX_ROUNDS+1)-1:0]    round_num,
    output logic                               round_start,
    output logic [1:0]                         round_winner
);

    localparam int RW = $clog2(ROUNDS_TO_WIN + 1);
    localparam int NW = $clog2(MAX_ROUNDS + 1);

    localparam logic [RW-1:0]      c_rounds_to_win = RW'(ROUNDS_TO_WIN);
    localparam logic [NW-1:0]      c_max_rounds    = NW'(MAX_ROUNDS);
    localparam logic [TIMER_W-1:0] c_countdown     = TIMER_W'(COUNTDOWN_S);
    localparam logic [TIMER_W-1:0] c_round         = TIMER_W'(ROUND_S);
    localparam logic [TIMER_W-1:0] c_round_end     = TIMER_W'(ROUND_END_S);

    match_state_t       r_state;
    match_state_t       w_next;

    logic [RW-1:0]      r_p1_rounds;
    logic [RW-1:0]      r_p2_rounds;
    logic [NW-1:0]      r_round_num;
    logic [1:0]         r_round_winner;
    logic               r_round_start;

    logic               w_tick;
    logic               w_zero;
    logic               w_run;
    logic               w_expire;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_value;

    logic               w_new_match;
    logic               w_next_round;
    logic               w_decide;
    logic [1:0]         w_decision;

    // ------------------------------------------------------------------------
    // Timer run enable
    // ------------------------------------------------------------------------
`ifdef MATCH_PAUSE_EN
    assign w_run = is_active(r_state) && !pause;
`else
    logic w_pause_unused;
    assign w_pause_unused = pause;
    assign w_run          = is_active(r_state);
`endif

    // A timed phase ends on the tick that takes the counter from 1 to 0, so
    // each phase lasts exactly N full seconds; an already-zero counter
    // (e.g. a zero-length load) also ends it.
    assign w_expire = w_zero || (w_tick && (timer == TIMER_W'(1)));

    // Every state change reloads the timer, which also clears the prescaler
    // so the first second of the new state is full length.
    assign w_load = (w_next != r_state);

    always_comb begin
        w_load_value = '0;
        case (w_next)
            ST_COUNTDOWN: w_load_value = c_countdown;
            ST_FIGHT:     w_load_value = c_round;
            ST_ROUND_END: w_load_value = c_round_end;
            default:      w_load_value = '0;
        endcase
    end

    sec_down_timer #(
        .CLK_HZ  (CLK_HZ),
        .TIMER_W (TIMER_W)
    ) u_sec_down_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_value (w_load_value),
        .enable     (w_run),
        .count      (timer),
        .tick       (w_tick),
        .zero       (w_zero)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_new_match  = 1'b0;
        w_next_round = 1'b0;
        w_decide     = 1'b0;
        w_decision   = WIN_NONE;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next      = ST_COUNTDOWN;
                    w_new_match = 1'b1;
                end
            end

            ST_COUNTDOWN: begin
                if (w_expire) begin
                    w_next = ST_FIGHT;
                end
            end

            ST_FIGHT: begin
                // KO outranks time-out, so a KO landing on the final tick is
                // credited as a KO.
                if ((p1_health == '0) && (p2_health == '0)) begin
                    w_decide   = 1'b1;
                    w_decision = WIN_DRAW;
                end else if (p1_health == '0) begin
                    w_decide   = 1'b1;
                    w_decision = WIN_P2;
                end else if (p2_health == '0) begin
                    w_decide   = 1'b1;
                    w_decision = WIN_P1;
                end else if (w_expire) begin
                    w_decide = 1'b1;
                    if (p1_health > p2_health) begin
                        w_decision = WIN_P1;
                    end else if (p2_health > p1_health) begin
                        w_decision = WIN_P2;
                    end else begin
                        w_decision = WIN_DRAW;
                    end
                end
                if (w_decide) begin
                    w_next = ST_ROUND_END;
                end
            end

            ST_ROUND_END: begin
                if (w_expire) begin
                    if (r_p1_rounds == c_rounds_to_win) begin
                        w_next = ST_P1_WIN;
                    end else if (r_p2_rounds == c_rounds_to_win) begin
                        w_next = ST_P2_WIN;
                    end else if (r_round_num == c_max_rounds) begin
                        if (r_p1_rounds > r_p2_rounds) begin
                            w_next = ST_P1_WIN;
                        end else if (r_p2_rounds > r_p1_rounds) begin
                            w_next = ST_P2_WIN;
                        end else begin
                            w_next = ST_EQ;
                        end
                    end else begin
                        w_next       = ST_COUNTDOWN;
                        w_next_round = 1'b1;
                    end
                end
            end

            ST_P1_WIN, ST_P2_WIN, ST_EQ: begin
                if (start) begin
                    w_next = ST_IDLE;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Score / round bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1_rounds    <= '0;
            r_p2_rounds    <= '0;
            r_round_num    <= '0;
            r_round_winner <= WIN_NONE;
            r_round_start  <= 1'b0;
        end else begin
            r_round_start <= (r_state == ST_COUNTDOWN) && (w_next == ST_FIGHT);

            if (w_new_match) begin
                r_p1_rounds    <= '0;
                r_p2_rounds    <= '0;
                r_round_num    <= NW'(1);
                r_round_winner <= WIN_NONE;
            end

            if (w_decide) begin
                r_round_winner <= w_decision;
                // Saturating: a count already at the target is never bumped.
                if ((w_decision == WIN_P1) && (r_p1_rounds < c_rounds_to_win)) begin
                    r_p1_rounds <= r_p1_rounds + RW'(1);
                end
                if ((w_decision == WIN_P2) && (r_p2_rounds < c_rounds_to_win)) begin
                    r_p2_rounds <= r_p2_rounds + RW'(1);
                end
            end

            if (w_next_round) begin
                r_round_num    <= r_round_num + NW'(1);
                r_round_winner <= WIN_NONE;
            end
        end
    end

    assign game_state   = r_state;
    assign p1_rounds    = r_p1_rounds;
    assign p2_rounds    = r_p2_rounds;
    assign round_num    = r_round_num;
    assign round_winner = r_round_winner;
    assign round_start  = r_round_start;

endmodule
`default_nettype wire

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter CLK_HZ, default 60, clk cycles per second tick.
REQ-002 SHALL have parameter COUNTDOWN_S, default 3, pre-round countdown length in seconds.
REQ-003 SHALL have parameter ROUND_S, default 99, round time limit in seconds; 1..2^TIMER_W-1.
REQ-004 SHALL have parameter ROUND_END_S, default 2, post-round hold in seconds.
REQ-005 SHALL have parameter ROUNDS_TO_WIN, default 2, round wins needed for the match.
REQ-006 SHALL have parameter MAX_ROUNDS, default 5, round cap including drawn rounds.
REQ-007 SHALL have parameters HEALTH_W, default 3, and TIMER_W, default 7.
REQ-008 SHALL have ports: clk input 1, system clock; reset input 1, asynchronous active-high reset.
REQ-009 SHALL have ports: start input 1, one-cycle start/acknowledge pulse; pause input 1, freeze request.
REQ-010 SHALL have ports: p1_health and p2_health, input HEALTH_W, current player health; 0 means KO.
REQ-011 SHALL have ports: game_state output 3, timer output TIMER_W, displayed seconds.
REQ-012 SHALL have ports: p1_rounds and p2_rounds output $clog2(ROUNDS_TO_WIN+1), round_num output $clog2(MAX_ROUNDS+1).
REQ-013 SHALL have ports: round_start output 1, player-reset pulse; round_winner output 2, 00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-014 State encoding SHALL be IDLE=0, COUNTDOWN=1, FIGHT=2, P1_WIN=3, P2_WIN=4, EQ=5, ROUND_END=6.
REQ-015 Second tick: prescaler 0..CLK_HZ-1, tick on CLK_HZ-1, cleared on every state entry so the first second is full length.
REQ-016 IDLE + start SHALL go to COUNTDOWN; scores are cleared, round_num=1, timer loads COUNTDOWN_S.
REQ-017 In COUNTDOWN the timer SHALL decrement per tick; on a tick at timer=1, go to FIGHT, load ROUND_S, and pulse round_start high for exactly one cycle.
REQ-018 FIGHT checks each cycle, in priority order: both health 0 -> draw; p1 0 -> P2 round; p2 0 -> P1 round; timer 0 -> higher health wins the round, equal health draws.
REQ-019 On round decision, SHALL increment the winner's round count in the same cycle, latch round_winner, go to ROUND_END, and load timer with ROUND_END_S.
REQ-020 A round decision and a tick in the same cycle: decision wins, timer not decremented.
REQ-021 On ROUND_END expiry, SHALL go to P1_WIN if p1_rounds=ROUNDS_TO_WIN, else P2_WIN if p2_rounds=ROUNDS_TO_WIN.
REQ-022 Otherwise, if round_num=MAX_ROUNDS, SHALL go to the state of the higher round count, or EQ if equal.
REQ-023 Otherwise, SHALL go to COUNTDOWN with round_num+1, round_winner=00, timer=COUNTDOWN_S.
REQ-024 P1_WIN, P2_WIN and EQ SHALL hold outputs until start, then go to IDLE.
REQ-025 start outside IDLE/terminal states SHALL be ignored.
REQ-026 Round counts SHALL never exceed ROUNDS_TO_WIN; timer SHALL never underflow below 0.
REQ-027 timer SHALL read 0 in IDLE and in terminal states.

Reset
REQ-028 reset SHALL asynchronously force IDLE, timer=0, rounds=0, round_num=0, round_winner=00, round_start=0, prescaler=0; reset mid-round discards all progress.

Configuration
REQ-029 With MATCH_PAUSE_EN defined, pause=1 in COUNTDOWN/FIGHT/ROUND_END SHALL freeze the prescaler and timer while KO checks stay active.
REQ-030 Without MATCH_PAUSE_EN, the pause port SHALL exist but be ignored.

Structure
REQ-031 State encodings and round_winner codes SHALL live in a shared package, match_pkg, reused by the display and player blocks.
REQ-032 The prescaler plus down-counter SHALL be one sub-module, sec_down_timer, with load, enable, and zero outputs.

Verification (CLK_HZ=4, COUNTDOWN_S=3, ROUND_S=5, ROUND_END_S=2, ROUNDS_TO_WIN=2, MAX_ROUNDS=3)
REQ-033 start, healths 7/7 held -> COUNTDOWN 12 cycles, round_start pulse, FIGHT 20 cycles, round_winner=11 (draw), rounds 0/0.
REQ-034 p2_health=0 at FIGHT cycle 3, twice -> p1_rounds=2, then P1_WIN after 8 ROUND_END cycles.
REQ-035 Health 0/0 together -> draw; three draws -> EQ, round_num=3.
REQ-036 KO on the same cycle the timer reaches 0 -> KO winner credited, not a timeout judgement.
REQ-037 reset asserted mid-FIGHT -> state immediately IDLE, all outputs 0.
REQ-038 MATCH_PAUSE_EN, pause held 10 cycles in FIGHT -> timer frozen; without the macro -> timer still decrements.
